// File: rtl/apg_sequencer.sv
// Sequencer for an arbitrary pattern generator (APG): it loads a pattern, checks the load count,
// runs the pattern the requested number of times and streams back each run's captured samples.
module apg_sequencer #(
    parameter int NUM_SIG     = 8,
    parameter int NUM_SAMP    = 128,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               axi_clk,
    input  logic               axi_reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_n_samples,
    input  logic [7:0]         cmd_repeat,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [NUM_SIG-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [NUM_SIG-1:0] m_data,
    output logic [7:0]         apg_write_channel,
    output logic               apg_write_strobe,
    output logic [31:0]        apg_n_samples,
    output logic               apg_run,
    input  logic [31:0]        apg_write_buffer_len,
    input  logic [2:0]         apg_status,
    input  logic [7:0]         apg_read_channel,
    output logic               apg_read_strobe,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] VERIFY = 3'd2;
    localparam logic [2:0] ARM    = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;
    localparam logic [2:0] DRAIN  = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    logic [2:0]         state_q, state_d;
    logic [31:0]        nSamp_q, nSamp_d;
    logic [31:0]        sampCnt_q, sampCnt_d;
    logic [31:0]        runCnt_q, runCnt_d;
    logic [31:0]        waitCnt_q, waitCnt_d;
    logic [1:0]         vfyCnt_q, vfyCnt_d;
    logic               rdPend_q, rdPend_d;
    logic               mValid_q, mValid_d;
    logic [NUM_SIG-1:0] mData_q, mData_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               wrStrobe;
    logic [7:0]         wrChan;
    logic               rdStrobe;
    logic               unused_bits;

    always_comb begin
        state_d   = state_q;
        nSamp_d   = nSamp_q;
        sampCnt_d = sampCnt_q;
        runCnt_d  = runCnt_q;
        waitCnt_d = waitCnt_q;
        vfyCnt_d  = vfyCnt_q;
        rdPend_d  = 1'b0;
        mValid_d  = mValid_q;
        mData_d   = mData_q;
        done_d    = 1'b0;
        error_d   = error_q;
        wrStrobe  = 1'b0;
        wrChan    = '0;
        rdStrobe  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    nSamp_d   = cmd_n_samples;
                    runCnt_d  = (cmd_repeat == 8'd0) ? 32'd1 : {24'd0, cmd_repeat};
                    sampCnt_d = '0;
                    error_d   = 1'b0;
                    if (cmd_n_samples == 32'd0 || cmd_n_samples > 32'(NUM_SAMP)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (s_valid) begin
                    wrStrobe                = 1'b1;
                    wrChan[NUM_SIG-1:0]     = s_data;
                    sampCnt_d               = sampCnt_q + 32'd1;
                    if (sampCnt_q == nSamp_q - 32'd1) begin
                        state_d   = VERIFY;
                        sampCnt_d = '0;
                        vfyCnt_d  = '0;
                    end
                end
            end
            VERIFY: begin
                if (apg_write_buffer_len == nSamp_q) begin
                    state_d = ARM;
                end else if (vfyCnt_q == 2'd3) begin
                    state_d = ERR;
                    error_d = 1'b1;
                end else begin
                    vfyCnt_d = vfyCnt_q + 2'd1;
                end
            end
            ARM: begin
                state_d   = WAIT;
                waitCnt_d = '0;
            end
            // The APG status lags the run pulse, so the first two WAIT cycles are not trusted.
            WAIT: begin
                waitCnt_d = waitCnt_q + 32'd1;
                if (waitCnt_q + 32'd1 >= 32'(TIMEOUT_CYC)) begin
                    state_d = ERR;
                    error_d = 1'b1;
                end else if (waitCnt_q >= 32'd2 && !apg_status[0]) begin
                    state_d   = DRAIN;
                    sampCnt_d = '0;
                end
            end
            DRAIN: begin
                if (mValid_q) begin
                    if (m_ready) begin
                        mValid_d = 1'b0;
                        if (sampCnt_q == nSamp_q - 32'd1) begin
                            sampCnt_d = '0;
                            runCnt_d  = runCnt_q - 32'd1;
                            if (runCnt_q > 32'd1) begin
                                state_d = ARM;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            sampCnt_d = sampCnt_q + 32'd1;
                        end
                    end
                end else if (rdPend_q) begin
                    mValid_d = 1'b1;
                    mData_d  = apg_read_channel[NUM_SIG-1:0];
                end else begin
                    rdStrobe = 1'b1;
                    rdPend_d = 1'b1;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q   <= IDLE;
            nSamp_q   <= '0;
            sampCnt_q <= '0;
            runCnt_q  <= '0;
            waitCnt_q <= '0;
            vfyCnt_q  <= '0;
            rdPend_q  <= 1'b0;
            mValid_q  <= 1'b0;
            mData_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            nSamp_q   <= nSamp_d;
            sampCnt_q <= sampCnt_d;
            runCnt_q  <= runCnt_d;
            waitCnt_q <= waitCnt_d;
            vfyCnt_q  <= vfyCnt_d;
            rdPend_q  <= rdPend_d;
            mValid_q  <= mValid_d;
            mData_q   <= mData_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // State-decoded outputs are masked by reset so nothing strobes while it is held.
    assign cmd_ready         = (state_q == IDLE) && !axi_reset;
    assign s_ready           = (state_q == LOAD) && !axi_reset;
    assign apg_write_strobe  = wrStrobe && !axi_reset;
    assign apg_write_channel = axi_reset ? 8'd0 : wrChan;
    assign apg_run           = (state_q == ARM) && !axi_reset;
    assign apg_read_strobe   = rdStrobe && !axi_reset;
    assign busy              = (state_q != IDLE) && !axi_reset;
    assign apg_n_samples     = nSamp_q;
    assign m_valid           = mValid_q;
    assign m_data            = mData_q;
    assign done              = done_q;
    assign error             = error_q;
    assign unused_bits       = ^{apg_status[2:1], apg_read_channel};

endmodule

// File: tb/tb_apg_sequencer.sv
// Directed bench for apg_sequencer with a small echoing APG model and an output scoreboard.
module tb_apg_sequencer;

    logic        clk = 1'b0;
    logic        axi_reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_n_samples = '0;
    logic [7:0]  cmd_repeat = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic [7:0]  apg_write_channel;
    logic        apg_write_strobe;
    logic [31:0] apg_n_samples;
    logic        apg_run;
    logic [31:0] apg_write_buffer_len = '0;
    logic [2:0]  apg_status = '0;
    logic [7:0]  apg_read_channel = '0;
    logic        apg_read_strobe;
    logic        busy, done, error;

    int compared = 0;
    int mismatched = 0;

    // APG model and scoreboard state
    logic [7:0]  apgBuf [256];
    logic [31:0] lenCnt = '0;
    int          rdPtr = 0;
    int          runLeft = 0;
    bit          lenStuck = 0;
    bit          statusStuck = 0;
    bit          clearReq = 0;
    int          readyMode = 1;
    int          wrCnt = 0, runCnt = 0, rdCnt = 0, doneCnt = 0, stallViol = 0;
    logic [7:0]  outQ [$];
    bit          prevStall = 0, rstPrev = 1;
    logic [7:0]  prevData = '0;

    apg_sequencer #(.NUM_SIG(8), .NUM_SAMP(128), .TIMEOUT_CYC(100)) dut (
        .axi_clk(clk), .axi_reset(axi_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_n_samples(cmd_n_samples), .cmd_repeat(cmd_repeat),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .apg_write_channel(apg_write_channel), .apg_write_strobe(apg_write_strobe),
        .apg_n_samples(apg_n_samples), .apg_run(apg_run),
        .apg_write_buffer_len(apg_write_buffer_len), .apg_status(apg_status),
        .apg_read_channel(apg_read_channel), .apg_read_strobe(apg_read_strobe),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // m_ready driver: 0 = held low, 1 = held high, 2 = toggling every cycle
    initial begin
        forever begin
            @(posedge clk); #1;
            if (readyMode == 2) m_ready = ~m_ready;
            else m_ready = (readyMode == 1);
        end
    end

    // APG model: samples DUT strobes mid-cycle, updates its registered outputs just after the edge.
    initial begin
        logic       sw, sr, srs;
        logic [7:0] swc;
        forever begin
            @(negedge clk);
            if (prevStall && !rstPrev && (!m_valid || m_data != prevData)) stallViol++;
            prevStall = m_valid && !m_ready;
            prevData  = m_data;
            rstPrev   = axi_reset;
            sw = apg_write_strobe; swc = apg_write_channel; sr = apg_run; srs = apg_read_strobe;
            if (sw)  wrCnt++;
            if (sr)  runCnt++;
            if (srs) rdCnt++;
            if (done) doneCnt++;
            if (m_valid && m_ready) outQ.push_back(m_data);
            @(posedge clk); #1;
            if (clearReq) begin
                lenCnt = '0; rdPtr = 0; runLeft = 0;
                wrCnt = 0; runCnt = 0; rdCnt = 0; doneCnt = 0; stallViol = 0;
                outQ.delete(); prevStall = 0;
                apg_read_channel = '0;
                clearReq = 0;
            end else begin
                if (sw) begin apgBuf[lenCnt[7:0]] = swc; lenCnt = lenCnt + 32'd1; end
                if (sr) begin runLeft = 5; rdPtr = 0; end
                else if (runLeft > 0) runLeft--;
                if (srs) begin apg_read_channel = apgBuf[rdPtr[7:0]]; rdPtr++; end
            end
            apg_write_buffer_len = lenStuck ? 32'd2 : lenCnt;
            apg_status = {2'b00, (statusStuck || runLeft != 0)};
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] n, input logic [7:0] rep);
        int g = 0;
        while (!cmd_ready && g < 20) begin @(posedge clk); #1; g++; end
        cmd_n_samples = n; cmd_repeat = rep; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feedSamples(input int cnt, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < cnt; i++) begin
            int g = 0;
            while (!s_ready && g < 20) begin @(posedge clk); #1; g++; end
            s_valid = 1'b1; s_data = d[i];
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic waitFinish(input int maxCyc);
        int k = 0;
        do begin @(negedge clk); k++; end while (!done && !error && k < maxCyc);
        if (!done && !error) checkOutput("finishTimeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic clearModel();
        @(negedge clk); clearReq = 1;
        @(posedge clk); #2;
    endtask

    function automatic logic [31:0] getOut(input int i);
        return (i < outQ.size()) ? {24'd0, outQ[i]} : 32'hDEAD;
    endfunction

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1 axi_reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_cmdReady", 32'(cmd_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_mValid", 32'(m_valid), 32'd0);
        checkOutput("rst_nSamples", apg_n_samples, 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        clearModel();

        // basic load / run / drain with an echoing APG
        readyMode = 1;
        applyStimulus(32'd4, 8'd1);
        checkOutput("t1_nSamples", apg_n_samples, 32'd4);
        feedSamples(4, 8'h11, 8'h22, 8'h33, 8'h44);
        waitFinish(200);
        checkOutput("t1_writes", 32'(wrCnt), 32'd4);
        checkOutput("t1_runs", 32'(runCnt), 32'd1);
        checkOutput("t1_reads", 32'(rdCnt), 32'd4);
        checkOutput("t1_out0", getOut(0), 32'h11);
        checkOutput("t1_out1", getOut(1), 32'h22);
        checkOutput("t1_out2", getOut(2), 32'h33);
        checkOutput("t1_out3", getOut(3), 32'h44);
        checkOutput("t1_outCount", 32'(outQ.size()), 32'd4);
        checkOutput("t1_done", 32'(doneCnt), 32'd1);
        checkOutput("t1_error", 32'(error), 32'd0);
        clearModel();

        // illegal lengths: zero and one past the buffer depth
        applyStimulus(32'd0, 8'd1);
        @(negedge clk);
        checkOutput("t2a_error", 32'(error), 32'd1);
        @(negedge clk);
        checkOutput("t2a_cmdReady", 32'(cmd_ready), 32'd1);
        applyStimulus(32'd129, 8'd1);
        @(negedge clk);
        checkOutput("t2b_error", 32'(error), 32'd1);
        @(negedge clk);
        checkOutput("t2b_cmdReady", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("t2_writes", 32'(wrCnt), 32'd0);
        checkOutput("t2_runs", 32'(runCnt), 32'd0);
        clearModel();

        // APG reports a short load: four VERIFY cycles then ERR, never armed
        lenStuck = 1;
        applyStimulus(32'd3, 8'd2);
        checkOutput("t3_errCleared", 32'(error), 32'd0);
        feedSamples(3, 8'h01, 8'h02, 8'h03, 8'h00);
        k = 0;
        do begin @(negedge clk); k++; end while (!error && k < 30);
        checkOutput("t3_errCycle", 32'(k), 32'd5);
        @(posedge clk); #1;
        checkOutput("t3_runs", 32'(runCnt), 32'd0);
        checkOutput("t3_writes", 32'(wrCnt), 32'd3);
        clearModel();
        lenStuck = 0;

        // repeated runs with a stalling consumer
        readyMode = 2;
        applyStimulus(32'd2, 8'd3);
        feedSamples(2, 8'hA5, 8'h3C, 8'h00, 8'h00);
        waitFinish(500);
        checkOutput("t4_runs", 32'(runCnt), 32'd3);
        checkOutput("t4_outCount", 32'(outQ.size()), 32'd6);
        checkOutput("t4_out0", getOut(0), 32'hA5);
        checkOutput("t4_out1", getOut(1), 32'h3C);
        checkOutput("t4_out4", getOut(4), 32'hA5);
        checkOutput("t4_out5", getOut(5), 32'h3C);
        checkOutput("t4_stable", 32'(stallViol), 32'd0);
        checkOutput("t4_done", 32'(doneCnt), 32'd1);
        checkOutput("t4_error", 32'(error), 32'd0);
        readyMode = 1;
        clearModel();

        // APG never finishes: WAIT times out after TIMEOUT_CYC cycles
        statusStuck = 1;
        applyStimulus(32'd1, 8'd1);
        feedSamples(1, 8'h77, 8'h00, 8'h00, 8'h00);
        k = 0;
        do begin @(negedge clk); k++; end while (!apg_run && k < 50);
        checkOutput("t5_run", 32'(apg_run), 32'd1);
        k = 0;
        do begin @(negedge clk); k++; end while (!error && k < 150);
        checkOutput("t5_errCycle", 32'(k), 32'd101);
        @(negedge clk);
        checkOutput("t5_idleBusy", 32'(busy), 32'd0);
        checkOutput("t5_idleReady", 32'(cmd_ready), 32'd1);
        checkOutput("t5_reads", 32'(rdCnt), 32'd0);
        statusStuck = 0;
        clearModel();

        // reset while a captured sample waits in DRAIN
        readyMode = 0;
        applyStimulus(32'd2, 8'd1);
        feedSamples(2, 8'h12, 8'h34, 8'h00, 8'h00);
        k = 0;
        do begin @(negedge clk); k++; end while (!m_valid && k < 50);
        checkOutput("t6_pending", 32'(m_valid), 32'd1);
        @(posedge clk); #1 axi_reset = 1'b1;
        @(posedge clk); #1 axi_reset = 1'b0;
        @(negedge clk);
        checkOutput("t6_mValid", 32'(m_valid), 32'd0);
        checkOutput("t6_mData", 32'(m_data), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_cmdReady", 32'(cmd_ready), 32'd1);
        checkOutput("t6_nSamples", apg_n_samples, 32'd0);
        checkOutput("t6_rdStrobe", 32'(apg_read_strobe), 32'd0);
        clearModel();
        repeat (4) @(negedge clk);
        checkOutput("t6_noStrobes", 32'(rdCnt + runCnt + wrCnt), 32'd0);
        clearModel();
        readyMode = 1;
        applyStimulus(32'd1, 8'd0);
        feedSamples(1, 8'h5A, 8'h00, 8'h00, 8'h00);
        waitFinish(200);
        checkOutput("t6_runs", 32'(runCnt), 32'd1);
        checkOutput("t6_out0", getOut(0), 32'h5A);
        checkOutput("t6_done", 32'(doneCnt), 32'd1);
        checkOutput("t6_error", 32'(error), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
